rr_arb8_enc: RTL and testbench

RR_ARB8_ENC -- requirements
Module: rr_arb8_enc

---
 rtl/rr_arb_pkg.sv | 25 ++
 rtl/rr_pick8.sv | 40 ++++
 rtl/rr_arb8_enc.sv | 106 ++++++++++
 tb/tb_rr_arb8_enc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_pkg
//  Purpose  : Shared types and constants for the 8-way round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick8
//  Purpose  : Combinational round-robin picker; searches upward from ptr+1
//             with wrap-around and returns the first asserted request.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [IDXW:0]     w_base;
    logic [NREQ-1:0]   w_rot;
    logic [IDXW-1:0]   w_off;

    // Rotate so bit 0 of w_rot is requester ptr+1; the lowest set bit wins.
    assign w_dbl  = {req, req};
    assign w_base = {1'b0, ptr} + {{IDXW{1'b0}}, 1'b1};
    assign w_rot  = w_dbl[w_base +: NREQ];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDXW'(k);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + IDXW'(1) + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_arb8_enc.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb8_enc
//  Purpose  : 8-requester round-robin arbiter with one-hot and encoded grant.
//             Optional grant timeout enabled by defining RR_ARB8_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb8_enc
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            rel,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            tout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb8_enc: MAX_HOLD must be in 1..255");
    end

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic            w_any;
    logic [IDXW-1:0] w_idx;
    logic            w_release;

    rr_pick8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Explicit release and a dropped request collapse into one release event.
    assign w_release = rel | ~req[gnt_idx];

`ifdef RR_ARB8_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] r_cnt;
    logic       r_tout;
    assign tout = r_tout;
`else
    assign tout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            r_ptr   <= 3'd7;
`ifdef RR_ARB8_TIMEOUT_EN
            r_cnt   <= '0;
            r_tout  <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB8_TIMEOUT_EN
            r_tout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        gnt     <= idx_to_onehot(w_idx);
                        gnt_idx <= w_idx;
                        gnt_vld <= 1'b1;
                        r_ptr   <= w_idx;
`ifdef RR_ARB8_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        gnt     <= '0;
                        gnt_idx <= '0;
                        gnt_vld <= 1'b0;
`ifdef RR_ARB8_TIMEOUT_EN
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_state <= IDLE;
                        gnt     <= '0;
                        gnt_idx <= '0;
                        gnt_vld <= 1'b0;
                        r_tout  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_enc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb8_enc
//  Purpose  : Scoreboard bench for rr_arb8_enc: directed scenarios followed by
//             random traffic, checked against a behavioural arbiter model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb8_enc;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       tout;

    rr_arb8_enc #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tout    (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       vld;
        logic [2:0] idx;
        logic [7:0] gnt;
        logic       tout;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: owner = -1 means nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 7;
    int m_held  = 0;
    bit m_tout  = 1'b0;

    task automatic model_edge(input logic [7:0] r, input logic rl, input logic rs);
        m_tout = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 7;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (r[j] && m_owner < 0) begin
                    m_owner = j;
                    m_ptr   = j;
                    m_held  = 1;
                end
            end
        end else if (rl || !r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_held >= MAX_HOLD) begin
            m_owner = -1;
            m_tout  = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic rl, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            req = r;
            rel = rl;
            rst = rs;
            model_edge(r, rl, rs);
            e.due  = cyc + 1;
            e.vld  = (m_owner >= 0);
            e.idx  = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            e.gnt  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
            e.tout = m_tout;
            e.tag  = phase;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares each expectation once its edge has passed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (gnt_vld !== e.vld || gnt_idx !== e.idx || gnt !== e.gnt || tout !== e.tout) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got vld=%b idx=%0d gnt=%h tout=%b, want vld=%b idx=%0d gnt=%h tout=%b",
                         e.tag, cyc, gnt_vld, gnt_idx, gnt, tout, e.vld, e.idx, e.gnt, e.tout);
            end
        end
    end

    initial begin
        drive(8'h00, 1'b0, 1'b1, 3);

        phase = "reset_priority";
        drive(8'h81, 1'b0, 1'b0, 3);
        drive(8'h81, 1'b1, 1'b0, 1);
        drive(8'h81, 1'b0, 1'b0, 4);
        drive(8'h81, 1'b1, 1'b0, 1);
        drive(8'h00, 1'b0, 1'b0, 2);

        phase = "rotation";
        drive(8'h00, 1'b0, 1'b1, 1);
        drive(8'hFF, 1'b1, 1'b0, 20);
        drive(8'h00, 1'b0, 1'b0, 2);

        phase = "req_drop";
        drive(8'h00, 1'b0, 1'b1, 1);
        drive(8'h08, 1'b0, 1'b0, 2);
        drive(8'h28, 1'b0, 1'b0, 2);
        drive(8'h20, 1'b0, 1'b0, 3);
        drive(8'h00, 1'b0, 1'b0, 2);

        phase = "mid_grant_reset";
        drive(8'h40, 1'b0, 1'b0, 3);
        drive(8'h41, 1'b0, 1'b1, 1);
        drive(8'h41, 1'b0, 1'b0, 3);
        drive(8'h00, 1'b0, 1'b0, 2);

        phase = "hold_req2";
        drive(8'h04, 1'b0, 1'b0, 300);
        drive(8'h00, 1'b0, 1'b0, 2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            logic       rl;
            logic       rs;
            r  = 8'($urandom) & 8'($urandom);
            rl = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 49) == 0);
            drive(r, rl, rs, 1);
        end

        phase = "drain";
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
